// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU front end: instruction opcode constants,
// the bubble instruction, the PC increment and the fetch FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    // Major opcodes, found in instruction bits [15:12].
    localparam logic [3:0] OP_TYPEA = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b1000;
    localparam logic [3:0] OP_SW    = 4'b1011;
    localparam logic [3:0] OP_BLT   = 4'b0100;
    localparam logic [3:0] OP_BGT   = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // Bubble placed in IF/ID on flush, miss or drain.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // Instructions are two bytes wide; the PC is a byte address.
    localparam logic [15:0] PC_STEP = 16'd2;

    // RUN:  fetching, last request satisfied or first request of a run.
    // WAIT: fetching, previous cycle's request was not satisfied.
    // HALT: halt opcode accepted, no further requests until redirect/reset.
    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        HALT = 2'b10
    } fetch_state_e;

    // True when an instruction word carries the halt opcode.
    function automatic logic is_halt_op(input logic [3:0] op);
        return op == OP_HALT;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with load, hold and flush.
// Priority: rst > i_flush > i_load > hold.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_load             capture i_instr / i_pc_plus2 as a valid instruction
//   i_flush            replace contents with a bubble (NOP, invalid)
//   i_instr            fetched instruction word
//   i_pc_plus2         PC of i_instr plus 2
//   o_instr            registered instruction
//   o_pc_plus2         registered PC+2 of o_instr
//   o_valid            o_instr holds a real instruction
// -----------------------------------------------------------------------------
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_flush,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [15:0]        i_pc_plus2,
    output logic [INSTR_W-1:0] o_instr,
    output logic [15:0]        o_pc_plus2,
    output logic               o_valid
);

    logic [INSTR_W-1:0] r_instr;
    logic [15:0]        r_pc_plus2;
    logic               r_valid;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    // NOTE: the missing final else is intentional; in a clocked block it means
    // "hold", which is a flip-flop enable, not a latch.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_instr    <= INSTR_W'(NOP_INSTR);
            r_pc_plus2 <= 16'h0000;
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc_plus2 <= i_pc_plus2;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus2 = r_pc_plus2;
    assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: holds the PC, runs the RUN/WAIT/HALT fetch FSM and feeds
// the IF/ID register (if_id_reg). A returned instruction is accepted when
// imem_ready=1, stall=0 and redirect=0; it appears in IF/ID the next cycle.
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating perf counters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_addr / imem_req     fetch PC (byte address) and request
//   imem_rdata / imem_ready  returned instruction and its valid strobe
//   stall                    decode holds; PC and IF/ID frozen
//   redirect / redirect_pc   downstream branch/jump target, highest priority
//   id_instr / id_pc_plus2   IF/ID instruction and its PC+2
//   id_valid                 IF/ID holds a real instruction
//   opcode / funct           id_instr[15:12] / id_instr[3:0], zero on bubble
//   halted                   fetch stopped on halt opcode
//   perf_fetched/perf_stall  (FETCH_PERF_CNT_EN only) accepted fetches and
//                            stall-or-WAIT cycles, saturating
// -----------------------------------------------------------------------------
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          INSTR_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic [15:0]        imem_addr,
    output logic               imem_req,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    input  logic               stall,
    input  logic               redirect,
    input  logic [15:0]        redirect_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic [15:0]        id_pc_plus2,
    output logic               id_valid,
    output logic [3:0]         opcode,
    output logic [3:0]         funct,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_stall
`endif
);

    logic [15:0]  r_pc;
    fetch_state_e r_state;
    logic         r_imem_req;
    logic         r_halted;

    logic         w_running;
    logic         w_accept;
    logic         w_flush;
    logic         w_halt_op;
    logic [15:0]  w_pc_plus2;

    assign w_running  = (r_state != HALT);
    assign w_halt_op  = is_halt_op(imem_rdata[15:12]);
    assign w_pc_plus2 = r_pc + PC_STEP;   // wraps 16'hFFFE -> 16'h0000

    // An instruction is taken only when memory delivers, decode can take it
    // and no redirect is killing this fetch.
    assign w_accept = w_running && imem_ready && !stall && !redirect;

    // Bubble IF/ID when redirecting, or when decode drains (no stall) but
    // nothing new arrives: a memory miss, or fetch is halted.
    assign w_flush = redirect || (!stall && (!w_running || !imem_ready));

    // Fetch FSM and PC. imem_req and halted are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_state    <= RUN;
            r_imem_req <= 1'b1;
            r_halted   <= 1'b0;
        end else if (redirect) begin
            r_pc       <= redirect_pc;
            r_state    <= RUN;
            r_imem_req <= 1'b1;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                HALT: begin
                    // Stay put; only redirect or reset leave HALT.
                end
                default: begin
                    if (!imem_ready) begin
                        r_state <= WAIT;
                    end else if (stall) begin
                        // Returned word is dropped; the same PC is refetched.
                        r_state <= RUN;
                    end else begin
                        // The halt instruction itself advances the PC before
                        // fetch freezes.
                        r_pc <= w_pc_plus2;
                        if (w_halt_op) begin
                            r_state    <= HALT;
                            r_imem_req <= 1'b0;
                            r_halted   <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
            endcase
        end
    end

    if_id_reg #(
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_flush    (w_flush),
        .i_instr    (imem_rdata),
        .i_pc_plus2 (w_pc_plus2),
        .o_instr    (id_instr),
        .o_pc_plus2 (id_pc_plus2),
        .o_valid    (id_valid)
    );

    assign imem_addr = r_pc;
    assign imem_req  = r_imem_req;
    assign halted    = r_halted;
    assign opcode    = id_valid ? id_instr[15:12] : 4'b0000;
    assign funct     = id_valid ? id_instr[3:0]   : 4'b0000;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_perf_fetched;
    logic [15:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= 16'h0000;
            r_perf_stall   <= 16'h0000;
        end else begin
            if (w_accept && (r_perf_fetched != 16'hFFFF)) begin
                r_perf_fetched <= r_perf_fetched + 16'd1;
            end
            if ((stall || (r_state == WAIT)) && (r_perf_stall != 16'hFFFF)) begin
                r_perf_stall <= r_perf_stall + 16'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage: directed vector table, hand-written
// perf-counter sequence (FETCH_PERF_CNT_EN builds), and a randomized run
// checked against a behavioural model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] id_instr;
    logic [15:0] id_pc_plus2;
    logic        id_valid;
    logic [3:0]  opcode;
    logic [3:0]  funct;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_stall;
`endif

    fetch_stage #(
        .RESET_PC (16'h0000),
        .INSTR_W  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_instr    (id_instr),
        .id_pc_plus2 (id_pc_plus2),
        .id_valid    (id_valid),
        .opcode      (opcode),
        .funct       (funct),
        .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every visible output against one set of expectations.
    task automatic check_outputs(input string tag, input logic [15:0] e_addr,
                                 input logic e_halted, input logic e_valid,
                                 input logic [15:0] e_instr, input logic [15:0] e_pc2);
        check({tag, ".imem_addr"}, 32'(imem_addr), 32'(e_addr));
        check({tag, ".imem_req"},  32'(imem_req),  32'(!e_halted));
        check({tag, ".halted"},    32'(halted),    32'(e_halted));
        check({tag, ".id_valid"},  32'(id_valid),  32'(e_valid));
        check({tag, ".id_instr"},  32'(id_instr),  32'(e_instr));
        check({tag, ".opcode"},    32'(opcode),    32'(e_valid ? e_instr[15:12] : 4'h0));
        check({tag, ".funct"},     32'(funct),     32'(e_valid ? e_instr[3:0]   : 4'h0));
        if (e_valid) check({tag, ".id_pc_plus2"}, 32'(id_pc_plus2), 32'(e_pc2));
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic r, input logic rdy, input logic [15:0] rd,
                         input logic st, input logic rdr, input logic [15:0] rpc);
        rst = r; imem_ready = rdy; imem_rdata = rd;
        stall = st; redirect = rdr; redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, ready, stall, redir;
        logic [15:0] rdata, rpc;
        logic [15:0] e_addr, e_instr, e_pc2;
        logic        e_valid, e_halted;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(logic r, logic rdy, logic [15:0] rd, logic st,
                                logic rdr, logic [15:0] rpc, logic [15:0] ea,
                                logic [15:0] ei, logic [15:0] ep, logic ev, logic eh);
        vec_t v;
        v.rst = r; v.ready = rdy; v.rdata = rd; v.stall = st; v.redir = rdr; v.rpc = rpc;
        v.e_addr = ea; v.e_instr = ei; v.e_pc2 = ep; v.e_valid = ev; v.e_halted = eh;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    logic [15:0] m_pc, m_instr, m_pc2;
    logic        m_valid, m_halt, m_missed;
    int          m_fetched, m_stalls;

    task automatic model_step(input logic r, input logic rdy, input logic [15:0] rd,
                              input logic st, input logic rdr, input logic [15:0] rpc);
        if (r) begin
            m_pc = 16'h0000; m_halt = 0; m_missed = 0;
            m_instr = 16'h0000; m_valid = 0; m_fetched = 0; m_stalls = 0;
            return;
        end
        // A cycle counts as stalled if decode stalls or the previous request missed.
        if ((st || m_missed) && m_stalls < 65535) m_stalls++;
        if (rdr) begin
            m_pc = rpc; m_halt = 0; m_missed = 0;
            m_instr = 16'h0000; m_valid = 0;
        end else if (m_halt) begin
            if (!st) begin m_instr = 16'h0000; m_valid = 0; end
        end else if (st) begin
            m_missed = !rdy;
        end else if (!rdy) begin
            m_missed = 1; m_instr = 16'h0000; m_valid = 0;
        end else begin
            m_instr = rd; m_valid = 1;
            m_pc2 = 16'((32'(m_pc) + 2) % 65536);
            m_pc = m_pc2;
            m_missed = 0;
            m_halt = (rd[15:12] == 4'hF);
            if (m_fetched < 65535) m_fetched++;
        end
    endtask

    initial begin
        rst = 1; imem_ready = 0; imem_rdata = 0; stall = 0; redirect = 0; redirect_pc = 0;

        //            rst rdy rdata    st rdr rpc      e_addr   e_instr  e_pc2    v  h
        vecs[0]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        vecs[1]  = mk(0, 1, 16'h0123, 0, 0, 16'h0000, 16'h0002, 16'h0123, 16'h0002, 1, 0);
        vecs[2]  = mk(0, 1, 16'h8456, 0, 0, 16'h0000, 16'h0004, 16'h8456, 16'h0004, 1, 0);
        vecs[3]  = mk(0, 0, 16'hAAAA, 0, 0, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 0, 0);
        vecs[4]  = mk(0, 0, 16'hAAAA, 0, 0, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 0, 0);
        vecs[5]  = mk(0, 0, 16'hAAAA, 0, 0, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 0, 0);
        vecs[6]  = mk(0, 1, 16'h6012, 0, 0, 16'h0000, 16'h0006, 16'h6012, 16'h0006, 1, 0);
        vecs[7]  = mk(0, 1, 16'h1111, 1, 0, 16'h0000, 16'h0006, 16'h6012, 16'h0006, 1, 0);
        vecs[8]  = mk(0, 0, 16'h2222, 1, 0, 16'h0000, 16'h0006, 16'h6012, 16'h0006, 1, 0);
        vecs[9]  = mk(0, 1, 16'h3333, 1, 1, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 0, 0);
        vecs[10] = mk(0, 0, 16'h0000, 0, 1, 16'h000A, 16'h000A, 16'h0000, 16'h0000, 0, 0);
        vecs[11] = mk(0, 1, 16'hF000, 0, 0, 16'h0000, 16'h000C, 16'hF000, 16'h000C, 1, 1);
        vecs[12] = mk(0, 1, 16'h1234, 1, 0, 16'h0000, 16'h000C, 16'hF000, 16'h000C, 1, 1);
        vecs[13] = mk(0, 1, 16'h1234, 0, 0, 16'h0000, 16'h000C, 16'h0000, 16'h0000, 0, 1);
        vecs[14] = mk(0, 1, 16'h1234, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        vecs[15] = mk(0, 0, 16'h0000, 0, 1, 16'hFFFE, 16'hFFFE, 16'h0000, 16'h0000, 0, 0);
        vecs[16] = mk(0, 1, 16'h2345, 0, 0, 16'h0000, 16'h0000, 16'h2345, 16'h0000, 1, 0);
        vecs[17] = mk(1, 1, 16'h5555, 0, 1, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        vecs[18] = mk(0, 1, 16'h0111, 0, 0, 16'h0000, 16'h0002, 16'h0111, 16'h0002, 1, 0);
        vecs[19] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 0, 0);
        vecs[20] = mk(1, 1, 16'h0222, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        vecs[21] = mk(0, 1, 16'h0333, 0, 0, 16'h0000, 16'h0002, 16'h0333, 16'h0002, 1, 0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].ready, vecs[i].rdata, vecs[i].stall,
                  vecs[i].redir, vecs[i].rpc);
            check_outputs($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_halted,
                          vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc2);
        end

`ifdef FETCH_PERF_CNT_EN
        // Five accepted fetches with two cycles spent waiting on memory.
        drive(1, 0, 16'h0000, 0, 0, 16'h0000);
        check("perf.reset_fetched", 32'(perf_fetched), 32'd0);
        check("perf.reset_stall",   32'(perf_stall),   32'd0);
        drive(0, 1, 16'h0001, 0, 0, 16'h0000);
        drive(0, 1, 16'h0002, 0, 0, 16'h0000);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000);
        drive(0, 1, 16'h0003, 0, 0, 16'h0000);
        drive(0, 1, 16'h0004, 0, 0, 16'h0000);
        drive(0, 1, 16'h0005, 0, 0, 16'h0000);
        check("perf.fetched", 32'(perf_fetched), 32'd5);
        check("perf.stall",   32'(perf_stall),   32'd2);
        drive(1, 1, 16'h0006, 1, 0, 16'h0000);
        check("perf.rst_fetched", 32'(perf_fetched), 32'd0);
        check("perf.rst_stall",   32'(perf_stall),   32'd0);
`endif

        // ---------------- randomized run against the model ----------------
        for (int c = 0; c < 3000; c++) begin
            logic        r, rdy, st, rdr;
            logic [15:0] rd, rpc;
            r   = (c == 0) || ($urandom_range(0, 63) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 3) == 0);
            rdr = ($urandom_range(0, 15) == 0);
            rd  = 16'($urandom);
            rpc = 16'($urandom) & 16'hFFFE;
            // Occasionally jump near the top of memory to exercise the wrap.
            if ($urandom_range(0, 3) == 0) rpc = rpc | 16'hFFF0;
            drive(r, rdy, rd, st, rdr, rpc);
            model_step(r, rdy, rd, st, rdr, rpc);
            check_outputs($sformatf("rnd%0d", c), m_pc, m_halt, m_valid, m_instr, m_pc2);
`ifdef FETCH_PERF_CNT_EN
            check($sformatf("rnd%0d.perf_fetched", c), 32'(perf_fetched), 32'(m_fetched));
            check($sformatf("rnd%0d.perf_stall", c),   32'(perf_stall),   32'(m_stalls));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
